note_decoder: RTL

NOTE_DECODER -- requirements
Module: note_decoder

---
 rtl/note_decoder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/note_decoder.sv
// Tone period meter and piano note decoder: measures rising-edge spacing of a square-wave
// tone and reports a one-hot note once CONFIRM consecutive periods classify the same way.
module note_decoder #(
  parameter int unsigned TOL     = 1024,
  parameter int unsigned CONFIRM = 2,
  parameter int unsigned TIMEOUT = 131000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tone_in,
  output logic [7:0]  note,
  output logic        valid,
  output logic        note_strobe,
  output logic [16:0] period
);

  typedef enum logic [1:0] {StIdle, StMeasure, StLocked} state_e;

  localparam logic [16:0] CntMax     = 17'h1ffff;
  localparam logic [16:0] TolLim     = 17'(TOL);
  localparam logic [16:0] TimeoutLim = 17'(TIMEOUT);
  localparam logic [2:0]  ConfirmLim = 3'(CONFIRM);

  // Nominal periods in clocks, same bit order as the note output (C .. C2).
  localparam logic [16:0] Nominal [8] = '{
    17'd95567, 17'd85122, 17'd75851, 17'd71593,
    17'd63777, 17'd56819, 17'd50619, 17'd47775
  };

  state_e      state;
  logic        s0, s1, s2;
  logic        rise;
  logic        timeout;
  logic [16:0] cnt;
  logic [16:0] diff;
  logic [7:0]  cls;
  logic [7:0]  cand;
  logic        found;
  logic [2:0]  match_cnt;
  logic [2:0]  match_next;

  assign rise    = s1 & ~s2;
  assign timeout = (cnt >= TimeoutLim);

  // cnt holds the period ending in a rise cycle, so classify it directly.
  always_comb begin
    cls   = '0;
    found = 1'b0;
    diff  = '0;
    for (int i = 0; i < 8; i++) begin
      diff = (cnt >= Nominal[i]) ? (cnt - Nominal[i]) : (Nominal[i] - cnt);
      if (!found && (diff <= TolLim)) begin
        cls[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    if ((cls != 8'd0) && (cls == cand)) begin
      match_next = match_cnt + 3'd1;
    end else begin
      match_next = {2'b00, (cls != 8'd0)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      s0          <= 1'b0;
      s1          <= 1'b0;
      s2          <= 1'b0;
      cnt         <= '0;
      cand        <= '0;
      match_cnt   <= '0;
      note        <= '0;
      valid       <= 1'b0;
      note_strobe <= 1'b0;
      period      <= '0;
    end else begin
      s0          <= tone_in;
      s1          <= s0;
      s2          <= s1;
      note_strobe <= 1'b0;

      if (rise) begin
        cnt <= 17'd1;
      end else if (cnt != CntMax) begin
        cnt <= cnt + 17'd1;
      end

      if (rise) begin
        case (state)
          StIdle: begin
            state     <= StMeasure;
            cand      <= '0;
            match_cnt <= '0;
          end
          StMeasure: begin
            period    <= cnt;
            cand      <= cls;
            match_cnt <= match_next;
            // match_next is nonzero only for a real note, so locking never latches NONE.
            if (match_next == ConfirmLim) begin
              state       <= StLocked;
              note        <= cls;
              valid       <= 1'b1;
              note_strobe <= 1'b1;
            end
          end
          StLocked: begin
            period <= cnt;
            if (cls != note) begin
              cand      <= cls;
              match_cnt <= {2'b00, (cls != 8'd0)};
              if ((ConfirmLim == 3'd1) && (cls != 8'd0)) begin
                note        <= cls;
                valid       <= 1'b1;
                note_strobe <= 1'b1;
              end else begin
                state <= StMeasure;
                note  <= '0;
                valid <= 1'b0;
              end
            end
          end
          default: begin
            state <= StIdle;
          end
        endcase
      end else if ((state != StIdle) && timeout) begin
        state <= StIdle;
        note  <= '0;
        valid <= 1'b0;
      end
    end
  end

endmodule
